// File: rtl/dcache_mem_sequencer_if.sv
// rtl/dcache_mem_sequencer_if.sv - queue-head, memory-bus and core-response signals of the sequencer
interface dcache_mem_sequencer_if #(
  parameter int DATABITS = 32,
  parameter int ADDRBITS = 32
);
  logic [DATABITS-1:0] queue_out_data;
  logic [ADDRBITS-1:0] queue_out_addr;
  logic                queue_out_rdreq;
  logic                queue_out_wrreq;
  logic [1:0]          queue_out_wordlen;
  logic                queue_not_empty;
  logic                queue_pop;
  logic                mem_req;
  logic                mem_we;
  logic [ADDRBITS-1:0] mem_addr;
  logic [3:0]          mem_be;
  logic [DATABITS-1:0] mem_wdata;
  logic                mem_ack;
  logic [DATABITS-1:0] mem_rdata;
  logic                rd_valid;
  logic [DATABITS-1:0] rd_data;
  logic                wr_done;
  logic                err_valid;
  logic [1:0]          err_code;
  logic [ADDRBITS-1:0] err_addr;
  logic                busy;

  modport master (
    input  queue_out_data, queue_out_addr, queue_out_rdreq, queue_out_wrreq,
    input  queue_out_wordlen, queue_not_empty, mem_ack, mem_rdata,
    output queue_pop, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output rd_valid, rd_data, wr_done, err_valid, err_code, err_addr, busy
  );

  modport slave (
    output queue_out_data, queue_out_addr, queue_out_rdreq, queue_out_wrreq,
    output queue_out_wordlen, queue_not_empty, mem_ack, mem_rdata,
    input  queue_pop, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  rd_valid, rd_data, wr_done, err_valid, err_code, err_addr, busy
  );
endinterface

// File: rtl/dcache_mem_sequencer.sv
// rtl/dcache_mem_sequencer.sv - drains the dcache request queue into 32-bit word-addressed bus transactions
// with byte enables, ack timeout, and read/write/error completion pulses.
module dcache_mem_sequencer #(
  parameter int DATABITS    = 32,
  parameter int ADDRBITS    = 32,
  parameter int TIMEOUTBITS = 8
) (
  input logic clk,
  input logic reset,
  dcache_mem_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;

  localparam logic [TIMEOUTBITS-1:0] CNT_LAST = {{(TIMEOUTBITS-1){1'b1}}, 1'b0};

  state_t              state_q, state_d;
  logic [ADDRBITS-1:0] addr_q, addr_d;
  logic [1:0]          len_q, len_d;
  logic [TIMEOUTBITS-1:0] cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDRBITS-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [DATABITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATABITS-1:0] rd_data_q, rd_data_d;
  logic                wr_done_q, wr_done_d;
  logic                err_valid_q, err_valid_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [ADDRBITS-1:0] err_addr_q, err_addr_d;
  logic                busy_q, busy_d;
  logic                pop;

  function automatic logic [DATABITS-1:0] len_mask(input logic [1:0] len);
    case (len)
      2'd0:    len_mask = DATABITS'(8'hFF);
      2'd1:    len_mask = DATABITS'(16'hFFFF);
      default: len_mask = '1;
    endcase
  endfunction

  logic [4:0] q_sh, r_sh;
  logic [3:0] q_be;
  logic       q_illegal, q_misal;

  always_comb begin
    q_sh      = {bus.queue_out_addr[1:0], 3'b000};
    r_sh      = {addr_q[1:0], 3'b000};
    q_illegal = (bus.queue_out_rdreq == bus.queue_out_wrreq) || (bus.queue_out_wordlen == 2'd3);
    q_misal   = ((bus.queue_out_wordlen == 2'd1) && bus.queue_out_addr[0]) ||
                ((bus.queue_out_wordlen == 2'd2) && (bus.queue_out_addr[1:0] != 2'b00));
    case (bus.queue_out_wordlen)
      2'd0:    q_be = 4'b0001 << bus.queue_out_addr[1:0];
      2'd1:    q_be = 4'b0011 << bus.queue_out_addr[1:0];
      default: q_be = 4'b1111;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    wr_done_d   = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    err_addr_d  = err_addr_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.queue_not_empty) begin
          pop    = 1'b1;
          addr_d = bus.queue_out_addr;
          len_d  = bus.queue_out_wordlen;
          cnt_d  = '0;
          if (q_illegal || q_misal) begin
            state_d     = ERR;
            err_valid_d = 1'b1;
            err_code_d  = q_illegal ? 2'b10 : 2'b01;
            err_addr_d  = bus.queue_out_addr;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.queue_out_wrreq;
            mem_addr_d  = {bus.queue_out_addr[ADDRBITS-1:2], 2'b00};
            mem_be_d    = q_be;
            mem_wdata_d = (bus.queue_out_data & len_mask(bus.queue_out_wordlen)) << q_sh;
          end
        end
      end
      REQ: begin
        if (bus.mem_ack) begin
          // Writes also pass through RESP so wr_done and rd_valid share the same timing.
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (mem_we_q) begin
            wr_done_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = (bus.mem_rdata >> r_sh) & len_mask(len_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ERR;
          mem_req_d   = 1'b0;
          err_valid_d = 1'b1;
          err_code_d  = 2'b11;
          err_addr_d  = addr_q;
        end else begin
          cnt_d = cnt_q + TIMEOUTBITS'(1);
        end
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_done_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
      err_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      wr_done_q   <= wr_done_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      err_addr_q  <= err_addr_d;
      busy_q      <= busy_d;
    end
  end

  // The pop strobe is gated by reset so an abandoned cycle never consumes a queue entry.
  assign bus.queue_pop = pop && !reset;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.err_addr  = err_addr_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/dcache_mem_sequencer.md
Name: dcache_mem_sequencer

Overview:
- Drain stage directly downstream of the data-cache request queue.
- Pops one queued request (data, addr, rdreq, wrreq, wordlen) at a time and checks alignment and command legality.
- Converts sub-word accesses into a 32-bit word-addressed memory-bus transaction with byte enables, waits for the memory acknowledge under a timeout, and returns read data, write completion or an error to the core side.

Parameters:
DATABITS, 32, width of data path; fixed at 32, byte-lane logic assumes 4 lanes
ADDRBITS, 32, byte address width
TIMEOUTBITS, 8, width of ack-wait counter; timeout after 2**TIMEOUTBITS-1 cycles in REQ

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
queue_out_data  in  DATABITS  head-of-queue write data
queue_out_addr  in  ADDRBITS  head-of-queue byte address
queue_out_rdreq  in  1  head entry is a read
queue_out_wrreq  in  1  head entry is a write
queue_out_wordlen  in  2  0=byte, 1=halfword, 2=word, 3=illegal
queue_not_empty  in  1  queue holds at least one entry
queue_pop  out  1  one-cycle pop strobe to queue
mem_req  out  1  bus request, held until mem_ack
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  ADDRBITS  word-aligned address (bits [1:0]=0)
mem_be  out  4  byte enables
mem_wdata  out  DATABITS  lane-aligned write data
mem_ack  in  1  one-cycle completion; mem_rdata valid in same cycle
mem_rdata  in  DATABITS  read word
rd_valid  out  1  one-cycle pulse, rd_data valid
rd_data  out  DATABITS  zero-extended, right-justified read result
wr_done  out  1  one-cycle pulse on write completion
err_valid  out  1  one-cycle error pulse
err_code  out  2  01=misaligned, 10=illegal command, 11=timeout; held until next err_valid
err_addr  out  ADDRBITS  byte address of failing request; held until next err_valid
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, active-high, dominant) forces:
  - state=IDLE;
  - all outputs 0, including rd_data, err_code, err_addr and mem_* buses;
  - timeout counter 0.
- Reset mid-transaction abandons it; mem_req drops the cycle after reset is sampled, and no pulses are emitted.
- States: IDLE, REQ, RESP, ERR.
- IDLE: when queue_not_empty=1, latch the head entry, assert queue_pop for that cycle only, then check it:
  - illegal: rdreq==wrreq (both or neither set), or wordlen==3 -> ERR, code 10 (illegal takes priority over misaligned);
  - misaligned: halfword with a[0]=1, or word with a[1:0]!=0 -> ERR, code 01;
  - otherwise -> REQ.
- The queue head advances on the pop; the head is never sampled outside IDLE.
- REQ: mem_req=1 with all mem_* outputs stable until mem_ack.
  - mem_addr = {a[ADDRBITS-1:2],2'b00}; mem_we = wrreq.
  - mem_be: byte 4'b0001<<a[1:0]; halfword 4'b0011<<a[1:0]; word 4'b1111 (also driven for reads).
  - mem_wdata = (data masked to access width) << 8*a[1:0]; unused lanes 0.
  - The counter increments each REQ cycle without ack; reaching 2**TIMEOUTBITS-1 -> ERR, code 11, and mem_req drops.
  - mem_ack on a write: wr_done pulses the next cycle, then -> IDLE.
  - mem_ack on a read: capture (mem_rdata >> 8*a[1:0]) masked to width -> RESP.
  - mem_ack outside REQ is ignored.
- RESP: rd_valid=1 for one cycle, rd_data holds the value until the next read, -> IDLE.
- ERR: err_valid=1 for one cycle with err_code/err_addr, -> IDLE.
- Minimum latency:
  - read: pop cycle T, mem_req at T+1, ack at T+1, rd_valid at T+2.
  - write: wr_done at T+2.
  - error from check: err_valid at T+1.
- Back-to-back throughput: the next pop occurs in the IDLE cycle following RESP/ERR or wr_done.
- At most one outstanding bus transaction; the block never pops while busy.

Test Plan:
- Word read: addr 0x100, wordlen 2, ack after 3 cycles with mem_rdata 0xDEADBEEF -> one queue_pop; mem_addr 0x100, be 1111, mem_we 0; rd_valid once with rd_data 0xDEADBEEF.
- Byte write: addr 0x203, data 0x000000A5, wordlen 0 -> mem_addr 0x200, be 1000, mem_wdata 0xA5000000, mem_we 1; wr_done one cycle after ack.
- Halfword read: addr 0x302, rdata 0x12345678 -> be 1100, rd_data 0x00001234.
- Misaligned/illegal checks:
  - word at 0x401 -> no mem_req; err_valid, err_code 01, err_addr 0x401.
  - entry with rdreq=wrreq=1 -> err_code 10.
  - wordlen 3 with rdreq=1 -> err_code 10.
- Timeout: TIMEOUTBITS=3, never ack -> mem_req held 7 cycles, then err_code 11 and mem_req low; the next queued read then completes normally.
- Reset in REQ: assert reset while mem_req=1 -> next cycle all outputs 0, state IDLE; no rd_valid/wr_done/err_valid; a queue of 3 entries drains with exactly 3 pops afterwards.
